// File: rtl/cmd_queue_pkg.sv
// Shared command types and default queue geometry for the command queue
// and the issuer that drains it.
package cmd_queue_pkg;

  localparam int QUEUE_DEPTH   = 16;
  localparam int QUEUE_RESERVE = 2;

  localparam int CMD_ID_W  = 4;
  localparam int CMD_DEP_W = 4;
  localparam int CMD_OP_W  = 8;

  typedef logic [CMD_ID_W-1:0] cmd_id_t;

  typedef struct packed {
    cmd_id_t               id;
    logic [CMD_DEP_W-1:0]  dep;
    logic [CMD_OP_W-1:0]   op;
  } cmd_t;

endpackage : cmd_queue_pkg

// File: rtl/cmd_queue.sv
// Circular command FIFO in front of the issuer. Two write sources share one
// storage write port: host pushes and issuer writebacks (writeback wins).
// RESERVE slots are kept free of host traffic so writebacks are not starved.
// A blocked detector counts writebacks since the last retire and flags when
// every queued entry has been bounced back without progress.
module cmd_queue
  import cmd_queue_pkg::*;
#(
  parameter int DEPTH   = QUEUE_DEPTH,
  parameter int RESERVE = QUEUE_RESERVE
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_host_valid,
  output logic                       o_host_ready,
  input  cmd_t                       i_host_cmd,
  input  logic                       i_write,
  input  cmd_t                       i_wb_cmd,
  input  logic                       i_read,
  output cmd_t                       o_cmd,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  input  logic                       i_retire,
  output logic                       o_all_blocked,
  output logic                       o_overflow,
  input  logic                       i_clr_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] HOST_LIM = CW'(DEPTH - RESERVE);

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_blk_cnt;
  logic          r_overflow;
  cmd_t          r_mem [DEPTH];

  logic          w_empty;
  logic          w_pop;
  logic          w_host_ready;
  logic          w_push;
  logic          w_wb_acc;
  logic          w_wb_drop;
  logic          w_wr_en;
  cmd_t          w_wr_data;

  // Saturating increment used by the blocked counter; it never exceeds DEPTH.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= FULL_CNT) ? FULL_CNT : v + CW'(1);
  endfunction

  assign w_empty = (r_count == '0);

  // A pop only happens when there is something to pop.
  assign w_pop = i_read & ~w_empty;

  // Host is held off whenever the issuer writes back this cycle (single
  // storage write port) and whenever only the reserved slots are left.
  assign w_host_ready = ~i_write & (r_count < HOST_LIM);
  assign w_push       = i_host_valid & w_host_ready;

  // A writeback at full still fits if the head leaves in the same cycle.
  assign w_wb_acc  = i_write & ((r_count < FULL_CNT) | w_pop);
  assign w_wb_drop = i_write & ~w_wb_acc;

  assign w_wr_en   = w_wb_acc | w_push;
  assign w_wr_data = i_write ? i_wb_cmd : i_host_cmd;

  // Read and write pointers; power-of-two depth lets them wrap naturally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
    end
  end

  // Occupancy: simultaneous write and pop leaves it unchanged.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else begin
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Writebacks since the last retire; retire takes priority.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_blk_cnt <= '0;
    end else if (i_retire) begin
      r_blk_cnt <= '0;
    end else if (w_wb_acc) begin
      r_blk_cnt <= sat_inc(r_blk_cnt);
    end
  end

  // Sticky drop flag; a new drop wins over a clear in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overflow <= 1'b0;
    end else if (w_wb_drop) begin
      r_overflow <= 1'b1;
    end else if (i_clr_err) begin
      r_overflow <= 1'b0;
    end
  end

  // Command storage; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_data;
  end

  // Head is presented combinationally and forced to zero when empty so
  // stale storage never leaks onto the output.
  always_comb begin
    o_cmd = '0;
    if (!w_empty) o_cmd = r_mem[r_rd_ptr];
  end

  assign o_host_ready  = w_host_ready;
  assign o_empty       = w_empty;
  assign o_count       = r_count;
  assign o_overflow    = r_overflow;
  assign o_all_blocked = ~w_empty & (r_blk_cnt >= r_count);

endmodule : cmd_queue

// File: tb/tb_cmd_queue.sv
// Self-checking bench for cmd_queue: directed scenarios followed by
// randomized traffic compared against a queue-based reference model.
module tb_cmd_queue;
  import cmd_queue_pkg::*;

  localparam int D    = 16;
  localparam int R    = 2;
  localparam int CW   = $clog2(D+1);
  localparam int CMDW = $bits(cmd_t);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hv = 1'b0, wr = 1'b0, rd = 1'b0, ret = 1'b0, clr = 1'b0;
  cmd_t          hc = '0, wb = '0;
  logic          hready, empty, blocked, ovf;
  cmd_t          ocmd;
  logic [CW-1:0] cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  cmd_t mq[$];
  int   m_blk = 0;
  bit   m_ovf = 1'b0;

  cmd_queue #(.DEPTH(D), .RESERVE(R)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_host_valid(hv), .o_host_ready(hready), .i_host_cmd(hc),
    .i_write(wr), .i_wb_cmd(wb), .i_read(rd),
    .o_cmd(ocmd), .o_empty(empty), .o_count(cnt),
    .i_retire(ret), .o_all_blocked(blocked),
    .o_overflow(ovf), .i_clr_err(clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic cmd_t rnd_cmd();
    logic [CMDW-1:0] v;
    v = CMDW'($urandom);
    return cmd_t'(v);
  endfunction

  function automatic cmd_t mk(input int dep);
    cmd_t c;
    c = rnd_cmd();
    c.dep = CMD_DEP_W'(dep);
    return c;
  endfunction

  task automatic idle();
    hv = 1'b0; wr = 1'b0; rd = 1'b0; ret = 1'b0; clr = 1'b0;
  endtask

  // Advance one clock with the current inputs and update the model from the
  // queue rules: pops leave the front, accepted writes join the back.
  task automatic cyc();
    bit   pop, hr, push, wba, drop;
    int   sz;
    cmd_t t;
    sz   = mq.size();
    pop  = rd && (sz != 0);
    hr   = !wr && (sz < D - R);
    push = hv && hr;
    wba  = wr && ((sz < D) || pop);
    drop = wr && !wba;
    @(posedge clk); #1;
    if (pop) t = mq.pop_front();
    if (wba) mq.push_back(wb);
    else if (push) mq.push_back(hc);
    if (ret) m_blk = 0;
    else if (wba) m_blk = (m_blk + 1 > D) ? D : m_blk + 1;
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    #2 rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    mq.delete(); m_blk = 0; m_ovf = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
    n_vec++; if (cnt !== CW'(0)) begin n_err++; $display("FAIL reset_count got %0d want 0", cnt); end
    n_vec++; if (ocmd !== cmd_t'(0)) begin n_err++; $display("FAIL reset_cmd got %h want 0", ocmd); end
    n_vec++; if (hready !== 1'b1) begin n_err++; $display("FAIL reset_host_ready got %b want 1", hready); end
    n_vec++; if (blocked !== 1'b0) begin n_err++; $display("FAIL reset_all_blocked got %b want 0", blocked); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", ovf); end
  endtask

  task automatic test_fifo_order();
    do_reset();
    for (int i = 1; i <= 3; i++) begin hv = 1'b1; hc = mk(i); cyc(); end
    idle();
    n_vec++; if (cnt !== CW'(3)) begin n_err++; $display("FAIL order_count got %0d want 3", cnt); end
    n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL order_empty got %b want 0", empty); end
    for (int i = 1; i <= 3; i++) begin
      n_vec++; if (ocmd.dep !== CMD_DEP_W'(i)) begin n_err++; $display("FAIL order_dep got %0d want %0d", ocmd.dep, i); end
      n_vec++; if (ocmd !== mq[0]) begin n_err++; $display("FAIL order_cmd got %h want %h", ocmd, mq[0]); end
      rd = 1'b1; cyc(); rd = 1'b0;
    end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL order_end_empty got %b want 1", empty); end
    n_vec++; if (ocmd !== cmd_t'(0)) begin n_err++; $display("FAIL order_end_cmd got %h want 0", ocmd); end
  endtask

  task automatic test_fill_reserve();
    int n;
    do_reset();
    n = 0;
    hv = 1'b1;
    while (hready === 1'b1 && n < D + 2) begin hc = rnd_cmd(); cyc(); n++; end
    hv = 1'b0;
    n_vec++; if (cnt !== CW'(D - R)) begin n_err++; $display("FAIL fill_count got %0d want %0d", cnt, D - R); end
    n_vec++; if (hready !== 1'b0) begin n_err++; $display("FAIL fill_host_ready got %b want 0", hready); end
    for (int k = 0; k < R; k++) begin wr = 1'b1; wb = rnd_cmd(); cyc(); end
    wr = 1'b0;
    n_vec++; if (cnt !== CW'(D)) begin n_err++; $display("FAIL fill_wb_count got %0d want %0d", cnt, D); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL fill_wb_overflow got %b want 0", ovf); end
    wr = 1'b1; wb = rnd_cmd(); cyc(); wr = 1'b0;
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL drop_overflow got %b want 1", ovf); end
    n_vec++; if (cnt !== CW'(D)) begin n_err++; $display("FAIL drop_count got %0d want %0d", cnt, D); end
    clr = 1'b1; cyc(); clr = 1'b0;
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL clr_overflow got %b want 0", ovf); end
  endtask

  // Runs right after test_fill_reserve, with the queue full.
  task automatic test_full_pop_write();
    cmd_t x;
    x = rnd_cmd();
    rd = 1'b1; wr = 1'b1; wb = x; cyc(); idle();
    n_vec++; if (cnt !== CW'(D)) begin n_err++; $display("FAIL fullrw_count got %0d want %0d", cnt, D); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL fullrw_overflow got %b want 0", ovf); end
    for (int k = 0; k < D - 1; k++) begin rd = 1'b1; cyc(); end
    rd = 1'b0;
    n_vec++; if (cnt !== CW'(1)) begin n_err++; $display("FAIL fullrw_tail_count got %0d want 1", cnt); end
    n_vec++; if (ocmd !== x) begin n_err++; $display("FAIL fullrw_tail_cmd got %h want %h", ocmd, x); end
    rd = 1'b1; cyc(); rd = 1'b0;
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL fullrw_drained got %b want 1", empty); end
  endtask

  task automatic test_collision();
    cmd_t a, b;
    do_reset();
    a = mk(5); b = mk(6);
    hv = 1'b1; hc = a; wr = 1'b1; wb = b; #1;
    n_vec++; if (hready !== 1'b0) begin n_err++; $display("FAIL coll_ready_during_wb got %b want 0", hready); end
    cyc(); wr = 1'b0; #1;
    n_vec++; if (cnt !== CW'(1)) begin n_err++; $display("FAIL coll_count got %0d want 1", cnt); end
    n_vec++; if (ocmd !== b) begin n_err++; $display("FAIL coll_head got %h want %h", ocmd, b); end
    n_vec++; if (hready !== 1'b1) begin n_err++; $display("FAIL coll_ready_after got %b want 1", hready); end
    cyc(); hv = 1'b0;
    n_vec++; if (cnt !== CW'(2)) begin n_err++; $display("FAIL coll_host_count got %0d want 2", cnt); end
    rd = 1'b1; cyc(); rd = 1'b0;
    n_vec++; if (ocmd !== a) begin n_err++; $display("FAIL coll_second got %h want %h", ocmd, a); end
  endtask

  task automatic test_all_blocked();
    do_reset();
    for (int i = 1; i <= 3; i++) begin hv = 1'b1; hc = mk(i); cyc(); end
    idle();
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (blocked !== 1'b0) begin n_err++; $display("FAIL blk_early step %0d got %b want 0", k, blocked); end
      rd = 1'b1; wr = 1'b1; wb = ocmd; cyc(); idle();
    end
    n_vec++; if (blocked !== 1'b1) begin n_err++; $display("FAIL blk_set got %b want 1", blocked); end
    n_vec++; if (cnt !== CW'(3)) begin n_err++; $display("FAIL blk_count got %0d want 3", cnt); end
    ret = 1'b1; cyc(); ret = 1'b0;
    n_vec++; if (blocked !== 1'b0) begin n_err++; $display("FAIL blk_retire got %b want 0", blocked); end
  endtask

  task automatic test_reset_midstream();
    cmd_t p;
    do_reset();
    for (int i = 0; i < 5; i++) begin hv = 1'b1; hc = rnd_cmd(); cyc(); end
    idle();
    n_vec++; if (cnt !== CW'(5)) begin n_err++; $display("FAIL mid_pre_count got %0d want 5", cnt); end
    #2 rst = 1'b1; #1;
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL mid_empty got %b want 1", empty); end
    n_vec++; if (cnt !== CW'(0)) begin n_err++; $display("FAIL mid_count got %0d want 0", cnt); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL mid_overflow got %b want 0", ovf); end
    n_vec++; if (ocmd !== cmd_t'(0)) begin n_err++; $display("FAIL mid_cmd got %h want 0", ocmd); end
    @(negedge clk) rst = 1'b0;
    mq.delete(); m_blk = 0; m_ovf = 1'b0;
    p = rnd_cmd();
    hv = 1'b1; hc = p; cyc(); hv = 1'b0;
    n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL mid_push_empty got %b want 0", empty); end
    n_vec++; if (ocmd !== p) begin n_err++; $display("FAIL mid_push_cmd got %h want %h", ocmd, p); end
  endtask

  task automatic test_random();
    int   ph, p_hv, p_wr, p_rd, sz;
    bit   exp_hr, exp_blk;
    cmd_t exp_cmd;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      ph = (i / 100) % 4;
      case (ph)
        0:       begin p_hv = 80; p_wr = 40; p_rd = 10; end
        1:       begin p_hv = 60; p_wr = 70; p_rd = 20; end
        2:       begin p_hv = 20; p_wr = 10; p_rd = 80; end
        default: begin p_hv = 50; p_wr = 30; p_rd = 50; end
      endcase
      hv  = ($urandom_range(0, 99) < p_hv);
      wr  = ($urandom_range(0, 99) < p_wr);
      rd  = ($urandom_range(0, 99) < p_rd);
      ret = ($urandom_range(0, 99) < 5);
      clr = ($urandom_range(0, 99) < 5);
      hc  = rnd_cmd();
      wb  = rnd_cmd();
      #1;
      exp_hr = !wr && (mq.size() < D - R);
      n_vec++; if (hready !== exp_hr) begin n_err++; $display("FAIL rnd_host_ready cyc %0d got %b want %b", i, hready, exp_hr); end
      cyc();
      sz      = mq.size();
      exp_cmd = (sz != 0) ? mq[0] : cmd_t'(0);
      exp_blk = (sz != 0) && (m_blk >= sz);
      n_vec++; if (cnt !== CW'(sz)) begin n_err++; $display("FAIL rnd_count cyc %0d got %0d want %0d", i, cnt, sz); end
      n_vec++; if (empty !== (sz == 0)) begin n_err++; $display("FAIL rnd_empty cyc %0d got %b want %b", i, empty, sz == 0); end
      n_vec++; if (ocmd !== exp_cmd) begin n_err++; $display("FAIL rnd_cmd cyc %0d got %h want %h", i, ocmd, exp_cmd); end
      n_vec++; if (blocked !== exp_blk) begin n_err++; $display("FAIL rnd_all_blocked cyc %0d got %b want %b", i, blocked, exp_blk); end
      n_vec++; if (ovf !== m_ovf) begin n_err++; $display("FAIL rnd_overflow cyc %0d got %b want %b", i, ovf, m_ovf); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_fill_reserve();
    test_full_pop_write();
    test_collision();
    test_all_blocked();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_cmd_queue
